// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-PC sequencer with branch, jump, call and return.
// Define PC_RAS_EN to build the return-address stack; otherwise call acts as j.
module pc_sequencer #(
    parameter int          AW        = 32,
    parameter int          RAS_DEPTH = 4,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          z,
    input  logic          beq,
    input  logic          bne,
    input  logic          j,
    input  logic          call,
    input  logic          ret,
    input  logic [15:0]   imm16,
    input  logic [25:0]   imm26,
    output logic [AW-1:0] pc,
    output logic [4:0]    ras_count,
    output logic          ras_ovf,
    output logic          ras_unf
);

    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_seq;
    logic [AW-1:0] w_br;
    logic [AW-1:0] w_jmp;
    logic [AW-1:0] w_next;
    logic [31:0]   w_seq32;
    logic [31:0]   w_off32;
    logic [31:0]   w_jmp32;
    logic          w_take;
    logic          w_call;
    logic          w_j;
    logic          w_ret;

    assign w_seq   = r_pc + AW'(4);
    assign w_off32 = {{14{imm16[15]}}, imm16, 2'b00};
    assign w_br    = w_seq + w_off32[AW-1:0];
    assign w_seq32 = 32'(w_seq);
    assign w_jmp32 = (w_seq32 & 32'hF000_0000) | {4'b0000, imm26, 2'b00};
    assign w_jmp   = w_jmp32[AW-1:0];

    // A taken branch masks call/j/ret; call beats j, j beats ret.
    assign w_take = (beq & z) | (bne & ~z);
    assign w_call = ~w_take & call;
    assign w_j    = ~w_take & ~call & j;
    assign w_ret  = ~w_take & ~call & ~j & ret;

`ifdef PC_RAS_EN
    localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [AW-1:0] r_stack [RAS_DEPTH];
    logic [4:0]    r_cnt;
    logic          r_ovf;
    logic          r_unf;
    logic          w_full;
    logic          w_empty;
    logic [IW-1:0] w_top_idx;
    logic [IW-1:0] w_push_idx;

    assign w_full     = (r_cnt == 5'(RAS_DEPTH));
    assign w_empty    = (r_cnt == 5'd0);
    assign w_top_idx  = IW'(r_cnt - 5'd1);
    assign w_push_idx = IW'(r_cnt);

    // Next-PC select; an empty-stack return falls through to seq.
    always_comb begin
        w_next = w_seq;
        unique case (1'b1)
            w_take:  w_next = w_br;
            w_call:  w_next = w_jmp;
            w_j:     w_next = w_jmp;
            w_ret:   w_next = w_empty ? w_seq : r_stack[w_top_idx];
            default: w_next = w_seq;
        endcase
    end

    // Stack depth and sticky overflow/underflow flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 5'd0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (!stall) begin
            if (w_call) begin
                if (w_full) r_ovf <= 1'b1;
                else        r_cnt <= r_cnt + 5'd1;
            end else if (w_ret) begin
                if (w_empty) r_unf <= 1'b1;
                else         r_cnt <= r_cnt - 5'd1;
            end
        end
    end

    // Stack storage; a push into a full stack shifts out the oldest entry.
    always_ff @(posedge clk) begin
        if (!rst && !stall && w_call) begin
            if (w_full) begin
                for (int i = 0; i < RAS_DEPTH - 1; i++) begin
                    r_stack[i] <= r_stack[i+1];
                end
                r_stack[RAS_DEPTH-1] <= w_seq;
            end else begin
                r_stack[w_push_idx] <= w_seq;
            end
        end
    end

    assign ras_count = r_cnt;
    assign ras_ovf   = r_ovf;
    assign ras_unf   = r_unf;
`else
    // Next-PC select without a stack: call jumps, ret runs sequentially.
    always_comb begin
        w_next = w_seq;
        unique case (1'b1)
            w_take:  w_next = w_br;
            w_call:  w_next = w_jmp;
            w_j:     w_next = w_jmp;
            w_ret:   w_next = w_seq;
            default: w_next = w_seq;
        endcase
    end

    assign ras_count = 5'd0;
    assign ras_ovf   = 1'b0;
    assign ras_unf   = 1'b0;
`endif

    // PC register: reset wins, stall holds.
    always_ff @(posedge clk) begin
        if (rst)         r_pc <= RESET_VEC[AW-1:0];
        else if (!stall) r_pc <= w_next;
    end

    assign pc = r_pc;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter AW, default 32, meaning PC width in bits (legal 28..32).
REQ-002 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (legal 2..16).
REQ-003 SHALL have parameter RESET_VEC, default 32'h0000_0000, meaning PC value after reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  when high, the PC and stack hold.
REQ-007 SHALL have port z  input  1  ALU zero flag.
REQ-008 SHALL have ports beq, bne, j, call, ret  input  1 each  control strobes for the current instruction.
REQ-009 SHALL have port imm16  input  16  signed branch offset in words.
REQ-010 SHALL have port imm26  input  26  jump target word index.
REQ-011 SHALL have port pc  output  AW  current fetch address (registered).
REQ-012 SHALL have port ras_count  output  5  number of valid stack entries.
REQ-013 SHALL have ports ras_ovf, ras_unf  output  1 each  sticky overflow and underflow flags.

Function
REQ-014 SHALL compute seq = pc + 4, modulo 2^AW.
REQ-015 SHALL compute the branch target as seq + (sign-extended imm16 << 2), modulo 2^AW.
REQ-016 SHALL compute the jump target as seq with bits [27:0] replaced by {imm26, 2'b00}.
REQ-017 SHALL update the PC on each rising clk edge using the first matching rule in this priority order: rst; stall (hold); (beq & z) | (bne & ~z) -> branch target; call -> jump target plus push seq; j -> jump target; ret -> pop; otherwise seq.
REQ-018 SHALL ignore j, call and ret in any cycle where a branch is taken.
REQ-019 SHALL, on a push to a non-full stack, write seq to the top entry and increment ras_count.
REQ-020 SHALL, on a push to a full stack (ras_count == RAS_DEPTH), discard the oldest entry, store seq as the top entry, keep ras_count unchanged, and set ras_ovf.
REQ-021 SHALL, on a ret with a non-empty stack, load the top entry into the PC and decrement ras_count.
REQ-022 SHALL, on a ret with an empty stack, load seq into the PC and set ras_unf.
REQ-023 SHALL keep ras_ovf and ras_unf set until rst.
REQ-024 SHALL make the new PC visible on the pc output exactly one cycle after the control strobes are sampled, with no combinational path from inputs to pc.
REQ-025 SHALL freeze the PC, all stack entries, ras_count and both flags in any cycle where stall is high.

Reset
REQ-026 SHALL, when rst is high at a clk edge, set pc = RESET_VEC[AW-1:0], ras_count = 0, ras_ovf = 0 and ras_unf = 0, overriding stall and all strobes.
REQ-027 SHALL leave stack entry contents undefined after reset; entries are unreadable while ras_count is 0.
REQ-028 SHALL, when rst is asserted in the middle of a call/ret sequence, discard all pending stack state.

Configuration
REQ-029 SHALL, with PC_RAS_EN defined, include the return-address stack as specified above.
REQ-030 SHALL, with PC_RAS_EN undefined, omit the stack storage, treat call as j and ret as sequential, and tie ras_count, ras_ovf and ras_unf to 0.

Verification
REQ-031 SHALL cover: rst high for 1 cycle, then 3 idle cycles -> pc sequence 0x0, 0x4, 0x8, 0xC.
REQ-032 SHALL cover: pc = 0x100, beq = 1, z = 1, imm16 = 16'hFFFE -> next pc = 0xFC; same case with z = 0 -> next pc = 0x104.
REQ-033 SHALL cover: pc = 0x1000_0010, j = 1, imm26 = 26'h40 -> next pc = 0x1000_0100.
REQ-034 SHALL cover: pc = 0x20, call with imm26 = 26'h100 -> next pc = 0x400 and ras_count = 1; then ret -> next pc = 0x24 and ras_count = 0.
REQ-035 SHALL cover: 5 calls with RAS_DEPTH = 4 -> ras_ovf = 1 and ras_count = 4; 4 rets return the last 4 pushes in LIFO order; a 5th ret gives pc = seq and ras_unf = 1.
REQ-036 SHALL cover: stall held for 3 cycles during a call -> pc and ras_count unchanged, and the call takes effect in the first cycle after stall falls.
